lcd_timing_gen: RTL and testbench
=================================

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 480, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 2, front porch in clocks.
REQ-003 SHALL have parameter H_PULSE, default 41, hsync width in clocks.
REQ-004 SHALL have parameter H_BACK, default 2, back porch in clocks.
REQ-005 SHALL have parameter V_VISIBLE, default 272, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 2, front porch in lines.
REQ-007 SHALL have parameter V_PULSE, default 10, vsync width in lines.
REQ-008 SHALL have parameter V_BACK, default 2, back porch in lines.
REQ-009 SHALL have parameter HSYNC_POL, default 0, active level of hsync.
REQ-010 SHALL have parameter VSYNC_POL, default 0, active level of vsync.
REQ-011 SHALL have ports, in order:
  clock  in  1  sole clock;
  reset  in  1  asynchronous, active-high reset;
  enable  in  1  run timing when high;
  mode  in  2  0 external, 1 colour bars, 2 grid, 3 solid from pixel_color;
  pixel_color  in  16  RGB565 pixel, valid one clock after pixel_req;
  pixel_req  out  1  pixel fetch strobe;
  pixel_x  out  11  column of the requested pixel;
  pixel_y  out  11  row of the requested pixel;
  hsync  out  1  horizontal sync;
  vsync  out  1  vertical sync;
  display_enable  out  1  active-video qualifier;
  red, green, blue  out  8 each  RGB888 output;
  frame_start  out  1  one-clock pulse;
  line_start  out  1  one-clock pulse.

Function
REQ-012 SHALL count h from 0 to H_TOTAL-1, where H_TOTAL = H_VISIBLE+H_FRONT+H_PULSE+H_BACK; v SHALL advance on h wrap over 0..V_TOTAL-1 and wrap to 0 after V_TOTAL-1.
REQ-013 SHALL use 11-bit counters; H_TOTAL and V_TOTAL above 2048 SHALL be rejected at elaboration.
REQ-014 Stage 1, registered from the counters: pixel_req = (h<H_VISIBLE && v<V_VISIBLE); pixel_x=h and pixel_y=v while pixel_req is high, otherwise they hold their last values.
REQ-015 Stage 2, registered: hsync, vsync, display_enable and RGB SHALL lag pixel_req by exactly one clock; pixel_color SHALL be sampled on that edge.
REQ-016 hsync SHALL be at its active level while h is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_PULSE-1], delayed by two stages; vsync SHALL follow the same rule on v.
REQ-017 display_enable SHALL equal the delayed visible condition; outside visible, RGB SHALL be 0.
REQ-018 RGB565 SHALL expand by MSB replication: red={r[4:0],r[4:2]}, green={g[5:0],g[5:4]}, blue={b[4:0],b[4:2]}.
REQ-019 Mode 1 SHALL produce 8 equal vertical bars indexed by pixel_x*8/H_VISIBLE: white, yellow, cyan, green, magenta, red, blue, black; a remainder SHALL extend the last bar.
REQ-020 Mode 2 SHALL output white where pixel_x[4:0]==0 or pixel_y[4:0]==0, and black elsewhere.
REQ-021 mode SHALL be latched only when h==0 and v==0; a change mid-frame SHALL take effect from the next frame.
REQ-022 frame_start SHALL pulse aligned with the first display_enable of the frame; line_start SHALL pulse aligned with the first display_enable of each visible line.
REQ-023 enable low SHALL, on the next clock, hold the counters at 0, drive syncs inactive, and force display_enable, pixel_req and RGB to 0.
REQ-024 enable rising SHALL start at h=0, v=0, so that a full frame begins.

Reset
REQ-025 reset SHALL asynchronously force: counters 0; hsync=HSYNC_POL inverted; vsync=VSYNC_POL inverted; pixel_req, display_enable, frame_start, line_start 0; pixel_x, pixel_y, RGB 0; latched mode 0.
REQ-026 reset asserted mid-frame SHALL abort the frame; after release with enable high, timing SHALL restart at h=0, v=0.

Structure
REQ-027 Mode codes, the colour-bar table and default timing constants SHALL reside in package lcd_timing_pkg.
REQ-028 A sub-module lcd_axis_counter (parameterised limit, increment enable, wrap flag) SHALL be instantiated twice, once for h and once for v.

Verification
REQ-029 Defaults, enable=1, mode 0: period 525 clocks; hsync low 41 clocks; display_enable high 480 clocks per line and 272 lines per frame; frame period 150150 clocks.
REQ-030 pixel_color=16'hF800 held: red=8'hFF, green=0, blue=0, appearing exactly one clock after pixel_req.
REQ-031 Mode 1: pixel_x=0 gives FFFFFF; pixel_x=60 gives FFFF00; pixel_x=479 gives 000000.
REQ-032 Mode written 0 to 1 at v=100: the current frame stays external data; bars begin at the next frame_start.
REQ-033 enable dropped at h=200, v=50, then raised: outputs idle the next clock; the first frame_start follows after exactly V_BACK+... no skew, h=0, v=0 restart.
REQ-034 reset pulsed at h=300, v=150: all outputs take their reset values asynchronously; after release, the first pixel_req has x=0, y=0.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared constants for the LCD timing generator: default panel timing,
// display mode codes, the colour-bar table and the RGB565 expansion helper.
package lcd_timing_pkg;

    localparam int CNT_W         = 11;
    localparam int CNT_MAX_TOTAL = 2048;

    localparam int DEF_H_VISIBLE = 480;
    localparam int DEF_H_FRONT   = 2;
    localparam int DEF_H_PULSE   = 41;
    localparam int DEF_H_BACK    = 2;
    localparam int DEF_V_VISIBLE = 272;
    localparam int DEF_V_FRONT   = 2;
    localparam int DEF_V_PULSE   = 10;
    localparam int DEF_V_BACK    = 2;

    typedef enum logic [1:0] {
        MODE_EXTERNAL = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_GRID     = 2'd2,
        MODE_SOLID    = 2'd3
    } disp_mode_t;

    // Bars run left to right: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// Wrapping up-counter for one raster axis; wrap flags the increment that
// takes the count from LIMIT-1 back to 0.
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int LIMIT = 525
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Parallel-RGB LCD timing generator: raster counters, a pixel-fetch stage and
// a registered output stage carrying syncs, qualifier and pattern colour.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_PULSE   = DEF_H_PULSE,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_PULSE   = DEF_V_PULSE,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [15:0] pixel_color,
    output logic        pixel_req,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        hsync,
    output logic        vsync,
    output logic        display_enable,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_PULSE + V_BACK;

    // 12-bit bounds so a full 2048-count axis still compares correctly.
    localparam logic [11:0] H_VIS_END = 12'(H_VISIBLE);
    localparam logic [11:0] HS_START  = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_END    = 12'(H_VISIBLE + H_FRONT + H_PULSE);
    localparam logic [11:0] V_VIS_END = 12'(V_VISIBLE);
    localparam logic [11:0] VS_START  = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_END    = 12'(V_VISIBLE + V_FRONT + V_PULSE);

    if (H_TOTAL > CNT_MAX_TOTAL) begin : g_h_total_check
        $error("lcd_timing_gen: H_TOTAL %0d exceeds 11-bit counter range", H_TOTAL);
    end
    if (V_TOTAL > CNT_MAX_TOTAL) begin : g_v_total_check
        $error("lcd_timing_gen: V_TOTAL %0d exceeds 11-bit counter range", V_TOTAL);
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap_unused;

    lcd_axis_counter #(.LIMIT(H_TOTAL)) u_h_counter (
        .clock (clock),
        .reset (reset),
        .clear (!enable),
        .inc   (enable),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    lcd_axis_counter #(.LIMIT(V_TOTAL)) u_v_counter (
        .clock (clock),
        .reset (reset),
        .clear (!enable),
        .inc   (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap_unused)
    );

    logic h_vis, v_vis, vis, h_pulse, v_pulse, at_origin;

    assign h_vis     = {1'b0, h_cnt} < H_VIS_END;
    assign v_vis     = {1'b0, v_cnt} < V_VIS_END;
    assign vis       = h_vis && v_vis;
    assign h_pulse   = ({1'b0, h_cnt} >= HS_START) && ({1'b0, h_cnt} < HS_END);
    assign v_pulse   = ({1'b0, v_cnt} >= VS_START) && ({1'b0, v_cnt} < VS_END);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);

    disp_mode_t mode_q;
    logic       s1_hs, s1_vs, s1_frame, s1_line;

    // Mode is sampled at the raster origin, so a whole frame renders with one mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            mode_q <= MODE_EXTERNAL;
        else if (at_origin)
            mode_q <= disp_mode_t'(mode);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_req <= 1'b0;
            pixel_x   <= '0;
            pixel_y   <= '0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_frame  <= 1'b0;
            s1_line   <= 1'b0;
        end else if (!enable) begin
            pixel_req <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_frame  <= 1'b0;
            s1_line   <= 1'b0;
        end else begin
            pixel_req <= vis;
            if (vis) begin
                pixel_x <= h_cnt;
                pixel_y <= v_cnt;
            end
            s1_hs    <= h_pulse;
            s1_vs    <= v_pulse;
            s1_frame <= vis && at_origin;
            s1_line  <= vis && (h_cnt == '0);
        end
    end

    logic [2:0]  bar_idx;
    logic [23:0] rgb_next;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({pixel_x, 3'b000} >= 14'(k * H_VISIBLE))
                bar_idx = 3'(k);
        end
        case (mode_q)
            MODE_BARS: rgb_next = bar_color(bar_idx);
            MODE_GRID: rgb_next = ((pixel_x[4:0] == 5'd0) || (pixel_y[4:0] == 5'd0))
                                  ? 24'hFFFFFF : 24'h000000;
            default:   rgb_next = rgb565_to_888(pixel_color);
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync              <= ~HSYNC_POL;
            vsync              <= ~VSYNC_POL;
            display_enable     <= 1'b0;
            frame_start        <= 1'b0;
            line_start         <= 1'b0;
            {red, green, blue} <= '0;
        end else if (!enable) begin
            hsync              <= ~HSYNC_POL;
            vsync              <= ~VSYNC_POL;
            display_enable     <= 1'b0;
            frame_start        <= 1'b0;
            line_start         <= 1'b0;
            {red, green, blue} <= '0;
        end else begin
            hsync              <= s1_hs ? HSYNC_POL : ~HSYNC_POL;
            vsync              <= s1_vs ? VSYNC_POL : ~VSYNC_POL;
            display_enable     <= pixel_req;
            frame_start        <= s1_frame;
            line_start         <= s1_line;
            {red, green, blue} <= pixel_req ? rgb_next : 24'h000000;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: full-width lines with a short 8-line
// frame so whole frames, mode switches, enable drops and resets stay quick.
module tb_lcd_timing_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] pixel_color;
    logic        pixel_req;
    logic [10:0] pixel_x, pixel_y;
    logic        hsync, vsync, display_enable;
    logic [7:0]  red, green, blue;
    logic        frame_start, line_start;
    logic [23:0] rgb;

    int n_cmp = 0;
    int n_bad = 0;

    assign rgb = {red, green, blue};

    lcd_timing_gen #(
        .H_VISIBLE (480), .H_FRONT (2), .H_PULSE (41), .H_BACK (2),
        .V_VISIBLE (4),   .V_FRONT (1), .V_PULSE (2),  .V_BACK (1),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .pixel_color    (pixel_color),
        .pixel_req      (pixel_req),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .hsync          (hsync),
        .vsync          (vsync),
        .display_enable (display_enable),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .frame_start    (frame_start),
        .line_start     (line_start)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (!frame_start && n < 6000) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, frame_start}, 32'd1);
    endtask

    task automatic wait_line(input string tag);
        int n = 0;
        while (!line_start && n < 1000) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, line_start}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int per, de_n, ls_n, vs_n, hs_n, blank_rgb, run;

        reset = 1'b1; enable = 1'b1; mode = 2'd0; pixel_color = 16'hF800;
        #23;
        check_eq("rst_hsync", {31'd0, hsync}, 32'd1);
        check_eq("rst_vsync", {31'd0, vsync}, 32'd1);
        check_eq("rst_de", {31'd0, display_enable}, 32'd0);
        check_eq("rst_req", {31'd0, pixel_req}, 32'd0);
        check_eq("rst_rgb", {8'd0, rgb}, 32'd0);
        check_eq("rst_fs", {31'd0, frame_start}, 32'd0);

        @(negedge clock); reset = 1'b0;
        tick();
        check_eq("first_req", {31'd0, pixel_req}, 32'd1);
        check_eq("first_x", {21'd0, pixel_x}, 32'd0);
        check_eq("first_y", {21'd0, pixel_y}, 32'd0);
        check_eq("first_de_lag", {31'd0, display_enable}, 32'd0);
        tick();
        check_eq("first_de", {31'd0, display_enable}, 32'd1);
        check_eq("first_fs", {31'd0, frame_start}, 32'd1);
        check_eq("first_ls", {31'd0, line_start}, 32'd1);
        check_eq("f800_rgb", {8'd0, rgb}, 32'hFF0000);

        // One full frame of bookkeeping from this frame_start.
        per = 0; de_n = 0; ls_n = 0; vs_n = 0; hs_n = 0; blank_rgb = 0;
        do begin
            de_n += int'(display_enable);
            ls_n += int'(line_start);
            vs_n += int'(!vsync);
            hs_n += int'(!hsync);
            if (!display_enable && rgb != 24'd0) blank_rgb++;
            tick();
            per++;
        end while (!frame_start && per < 6000);
        check_eq("frame_period", per, 32'd4200);
        check_eq("de_per_frame", de_n, 32'd1920);
        check_eq("lines_per_frame", ls_n, 32'd4);
        check_eq("vsync_low", vs_n, 32'd1050);
        check_eq("hsync_low_frame", hs_n, 32'd328);
        check_eq("blank_rgb_nonzero", blank_rgb, 32'd0);

        run = 0;
        while (display_enable && run < 1000) begin tick(); run++; end
        check_eq("de_run", run, 32'd480);
        run = 0;
        while (hsync && run < 1000) begin tick(); run++; end
        check_eq("front_porch", run, 32'd2);
        run = 0;
        while (!hsync && run < 1000) begin tick(); run++; end
        check_eq("hsync_run", run, 32'd41);
        wait_line("ls_seen");
        tick();
        run = 1;
        while (!line_start && run < 1000) begin tick(); run++; end
        check_eq("line_period", run, 32'd525);

        // Colour bars: switch mid-frame, current frame stays external.
        tick(); wait_frame("fs_pre_bars");
        repeat (1000) tick();
        check_eq("ext_before_switch", {8'd0, rgb}, 32'hFF0000);
        mode = 2'd1;
        repeat (500) tick();
        check_eq("ext_after_switch", {8'd0, rgb}, 32'hFF0000);
        tick(); wait_frame("fs_bars");
        check_eq("bar_x0", {8'd0, rgb}, 32'hFFFFFF);
        repeat (59) tick();
        check_eq("bar_x59", {8'd0, rgb}, 32'hFFFFFF);
        tick();
        check_eq("bar_x60", {8'd0, rgb}, 32'hFFFF00);
        repeat (60) tick();
        check_eq("bar_x120", {8'd0, rgb}, 32'h00FFFF);
        repeat (359) tick();
        check_eq("bar_x479", {8'd0, rgb}, 32'h000000);
        check_eq("bar_x479_de", {31'd0, display_enable}, 32'd1);
        tick();
        check_eq("bar_x480_de", {31'd0, display_enable}, 32'd0);

        // Grid.
        mode = 2'd2;
        tick(); wait_frame("fs_grid");
        check_eq("grid_x0_y0", {8'd0, rgb}, 32'hFFFFFF);
        repeat (5) tick();
        check_eq("grid_x5_y0", {8'd0, rgb}, 32'hFFFFFF);
        tick(); wait_line("ls_grid");
        check_eq("grid_x0_y1", {8'd0, rgb}, 32'hFFFFFF);
        repeat (5) tick();
        check_eq("grid_x5_y1", {8'd0, rgb}, 32'h000000);
        repeat (27) tick();
        check_eq("grid_x32_y1", {8'd0, rgb}, 32'hFFFFFF);
        tick();
        check_eq("grid_x33_y1", {8'd0, rgb}, 32'h000000);

        // Solid and RGB565 expansion; pixel_color is sampled on the output edge.
        mode = 2'd3; pixel_color = 16'h8410;
        tick(); wait_frame("fs_solid");
        check_eq("solid_8410", {8'd0, rgb}, 32'h848284);
        repeat (5) tick();
        pixel_color = 16'h001F;
        tick();
        check_eq("solid_001f", {8'd0, rgb}, 32'h0000FF);

        // Enable drop mid-line, then restart from the origin.
        repeat (10) tick();
        enable = 1'b0;
        tick();
        check_eq("dis_de", {31'd0, display_enable}, 32'd0);
        check_eq("dis_req", {31'd0, pixel_req}, 32'd0);
        check_eq("dis_hsync", {31'd0, hsync}, 32'd1);
        check_eq("dis_vsync", {31'd0, vsync}, 32'd1);
        check_eq("dis_rgb", {8'd0, rgb}, 32'd0);
        repeat (3) tick();
        enable = 1'b1;
        tick();
        check_eq("ena_req", {31'd0, pixel_req}, 32'd1);
        check_eq("ena_x", {21'd0, pixel_x}, 32'd0);
        check_eq("ena_y", {21'd0, pixel_y}, 32'd0);
        tick();
        check_eq("ena_fs", {31'd0, frame_start}, 32'd1);
        check_eq("ena_rgb", {8'd0, rgb}, 32'h0000FF);

        // Asynchronous reset mid-line.
        mode = 2'd0; pixel_color = 16'hF800;
        repeat (20) tick();
        check_eq("pre_rst_rgb", {8'd0, rgb}, 32'hFF0000);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_de", {31'd0, display_enable}, 32'd0);
        check_eq("arst_req", {31'd0, pixel_req}, 32'd0);
        check_eq("arst_x", {21'd0, pixel_x}, 32'd0);
        check_eq("arst_rgb", {8'd0, rgb}, 32'd0);
        check_eq("arst_hsync", {31'd0, hsync}, 32'd1);
        @(negedge clock); reset = 1'b0;
        tick();
        check_eq("post_rst_req", {31'd0, pixel_req}, 32'd1);
        check_eq("post_rst_x", {21'd0, pixel_x}, 32'd0);
        check_eq("post_rst_y", {21'd0, pixel_y}, 32'd0);
        tick();
        check_eq("post_rst_fs", {31'd0, frame_start}, 32'd1);
        check_eq("post_rst_rgb", {8'd0, rgb}, 32'hFF0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
